game_sequencer: RTL and testbench

GAME_SEQUENCER -- requirements
Module: game_sequencer

---
 rtl/game_sequencer.sv | 149 ++++++++++++++
 tb/tb_game_sequencer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/game_sequencer.sv
// Game flow sequencer: attract loop, get-ready, timed play and times-up phases, then leaderboard.
// One prescaler produces the game-second tick; every timed phase counts seconds_left down on it.
module game_sequencer #(
    parameter int CLK_HZ       = 50000000,
    parameter int READY_SECS   = 3,
    parameter int GAME_SECS    = 60,
    parameter int TIMESUP_SECS = 3,
    parameter int NUM_SCREENS  = 4,
    parameter int SCREEN_SECS  = 5,
    parameter int PU_START     = 30,
    parameter int PU_LEN       = 5,
    parameter int SEC_W        = 8
) (
    input  logic                                                  clock,
    input  logic                                                  resetn,
    input  logic                                                  start,
    input  logic                                                  hold,
    input  logic                                                  abort,
    output logic [(NUM_SCREENS > 1 ? $clog2(NUM_SCREENS) : 1)-1:0] curr_screen,
    output logic [SEC_W-1:0]                                      seconds_left,
    output logic                                                  get_ready,
    output logic                                                  times_up,
    output logic                                                  leaderboard,
    output logic                                                  playing,
    output logic                                                  snitch_powerup,
    output logic                                                  end_of_game
);

    localparam int SCR_W = NUM_SCREENS > 1 ? $clog2(NUM_SCREENS) : 1;
    localparam int P_W   = CLK_HZ > 1 ? $clog2(CLK_HZ) : 1;
    localparam int SS_W  = SCREEN_SECS > 1 ? $clog2(SCREEN_SECS) : 1;

    localparam logic [P_W-1:0]   P_LAST   = P_W'(CLK_HZ - 1);
    localparam logic [SS_W-1:0]  SS_LAST  = SS_W'(SCREEN_SECS - 1);
    localparam logic [SCR_W-1:0] SCR_LAST = SCR_W'(NUM_SCREENS - 1);
    localparam bit               PU_EN    = (PU_LEN > 0) && (PU_START <= GAME_SECS);

    typedef enum logic [2:0] {IDLE, READY, PLAY, TIMESUP, BOARD} state_t;

    state_t            state, nxt_state;
    logic [P_W-1:0]    presc, nxt_presc;
    logic [SS_W-1:0]   scr_sec, nxt_scr_sec;
    logic [SCR_W-1:0]  nxt_screen;
    logic [SEC_W-1:0]  nxt_secs;
    logic              nxt_eog;
    logic              armed, nxt_armed;
    logic              sec_tick, accept;

    function automatic logic pu_hit(input logic [SEC_W-1:0] s);
        int si;
        si = int'(s);
        return PU_EN && (si <= PU_START) && (si > PU_START - PU_LEN);
    endfunction

    assign sec_tick = !hold && (presc == P_LAST);
    // armed drops when a game is accepted and only returns once start is seen low,
    // so a held start button launches exactly one game.
    assign accept   = start && armed && !hold;

    always_comb begin
        nxt_state   = state;
        nxt_presc   = hold ? presc : (sec_tick ? '0 : presc + P_W'(1));
        nxt_secs    = seconds_left;
        nxt_screen  = curr_screen;
        nxt_scr_sec = scr_sec;
        nxt_eog     = 1'b0;
        nxt_armed   = armed | ~start;
        if (abort) begin
            nxt_state   = IDLE;
            nxt_secs    = '0;
            nxt_screen  = '0;
            nxt_scr_sec = '0;
        end else if (!hold) begin
            case (state)
                IDLE, BOARD: begin
                    if (accept) begin
                        nxt_state = READY;
                        nxt_secs  = SEC_W'(READY_SECS);
                        nxt_armed = 1'b0;
                    end else if (state == IDLE && sec_tick) begin
                        if (scr_sec == SS_LAST) begin
                            nxt_scr_sec = '0;
                            nxt_screen  = (curr_screen == SCR_LAST) ? '0 : curr_screen + SCR_W'(1);
                        end else begin
                            nxt_scr_sec = scr_sec + SS_W'(1);
                        end
                    end
                end
                READY, PLAY, TIMESUP: begin
                    if (sec_tick) begin
                        if (seconds_left <= SEC_W'(1)) begin
                            case (state)
                                READY: begin
                                    nxt_state = PLAY;
                                    nxt_secs  = SEC_W'(GAME_SECS);
                                end
                                PLAY: begin
                                    nxt_state = TIMESUP;
                                    nxt_secs  = SEC_W'(TIMESUP_SECS);
                                    nxt_eog   = 1'b1;
                                end
                                default: begin
                                    nxt_state = BOARD;
                                    nxt_secs  = '0;
                                end
                            endcase
                        end else begin
                            nxt_secs = seconds_left - SEC_W'(1);
                        end
                    end
                end
                default: nxt_state = IDLE;
            endcase
        end
        // Each phase starts on a fresh second.
        if (nxt_state != state) nxt_presc = '0;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state          <= IDLE;
            presc          <= '0;
            scr_sec        <= '0;
            armed          <= 1'b1;
            curr_screen    <= '0;
            seconds_left   <= '0;
            get_ready      <= 1'b0;
            playing        <= 1'b0;
            times_up       <= 1'b0;
            leaderboard    <= 1'b0;
            snitch_powerup <= 1'b0;
            end_of_game    <= 1'b0;
        end else begin
            state          <= nxt_state;
            presc          <= nxt_presc;
            scr_sec        <= nxt_scr_sec;
            armed          <= nxt_armed;
            curr_screen    <= nxt_screen;
            seconds_left   <= nxt_secs;
            get_ready      <= (nxt_state == READY);
            playing        <= (nxt_state == PLAY);
            times_up       <= (nxt_state == TIMESUP);
            leaderboard    <= (nxt_state == BOARD);
            snitch_powerup <= (nxt_state == PLAY) && pu_hit(nxt_secs);
            end_of_game    <= nxt_eog;
        end
    end

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer with small timing parameters (4 cycles per second).
module tb_game_sequencer;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       start = 1'b0;
    logic       hold = 1'b0;
    logic       abort = 1'b0;
    logic [1:0] curr_screen;
    logic [7:0] seconds_left;
    logic       get_ready, times_up, leaderboard, playing, snitch_powerup, end_of_game;

    int n_chk = 0;
    int n_fail = 0;
    int secs_log [0:99];

    always #5 clock = ~clock;

    game_sequencer #(
        .CLK_HZ(4), .READY_SECS(2), .GAME_SECS(6), .TIMESUP_SECS(1),
        .NUM_SCREENS(3), .SCREEN_SECS(1), .PU_START(4), .PU_LEN(2), .SEC_W(8)
    ) dut (
        .clock(clock), .resetn(resetn), .start(start), .hold(hold), .abort(abort),
        .curr_screen(curr_screen), .seconds_left(seconds_left),
        .get_ready(get_ready), .times_up(times_up), .leaderboard(leaderboard),
        .playing(playing), .snitch_powerup(snitch_powerup), .end_of_game(end_of_game)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_flags"}, {get_ready, playing, times_up, leaderboard, snitch_powerup, end_of_game}, 0);
        check({tag, "_secs"}, seconds_left, 0);
    endtask

    // Pulses start, then samples n_cyc cycles; idx 0 is the first cycle after the start edge.
    task automatic run_game(input int n_cyc, input int hold_on, input int hold_off,
                            output int gr, output int pl, output int tu, output int eog,
                            output int sn, output int eog_idx, output int sn_first,
                            output int bad_onehot);
        gr = 0; pl = 0; tu = 0; eog = 0; sn = 0; eog_idx = -1; sn_first = -1; bad_onehot = 0;
        start = 1'b1;
        step(1);
        start = 1'b0;
        for (int i = 0; i < n_cyc; i++) begin
            secs_log[i] = seconds_left;
            gr += get_ready;
            pl += playing;
            tu += times_up;
            sn += snitch_powerup;
            if (end_of_game) begin
                eog++;
                eog_idx = i;
            end
            if (snitch_powerup && sn_first < 0) sn_first = i;
            if ((get_ready + playing + times_up + leaderboard) != 1) bad_onehot++;
            if (i == hold_on) hold = 1'b1;
            if (i == hold_off) hold = 1'b0;
            step(1);
        end
    endtask

    initial begin
        int gr, pl, tu, eog, sn, eog_idx, sn_first, bad, cnt_eog, cnt_gr;

        #2;
        check("reset_screen", curr_screen, 0);
        check_quiet("reset");
        #10 resetn = 1'b1;

        // Attract loop: screen steps every 4 cycles and wraps after the third screen.
        step(3);
        check("idle_scr_a", curr_screen, 0);
        step(1);
        check("idle_scr_b", curr_screen, 1);
        step(4);
        check("idle_scr_c", curr_screen, 2);
        step(4);
        check("idle_scr_wrap", curr_screen, 0);
        check_quiet("idle");

        // Plain game.
        run_game(40, -1, -1, gr, pl, tu, eog, sn, eog_idx, sn_first, bad);
        check("g1_ready_cyc", gr, 8);
        check("g1_play_cyc", pl, 24);
        check("g1_tu_cyc", tu, 4);
        check("g1_eog_cnt", eog, 1);
        check("g1_eog_idx", eog_idx, 32);
        check("g1_snitch_cyc", sn, 8);
        check("g1_snitch_first", sn_first, 16);
        check("g1_onehot", bad, 0);
        check("g1_secs_ready", secs_log[0], 2);
        check("g1_secs_play", secs_log[8], 6);
        check("g1_secs_tu", secs_log[32], 1);
        check("g1_board", leaderboard, 1);
        check("g1_board_secs", seconds_left, 0);

        // Start held through a whole game launches only one game.
        start = 1'b1;
        step(1);
        check("held_ready", get_ready, 1);
        step(44);
        check("held_board", leaderboard, 1);
        check("held_no_restart", get_ready, 0);
        start = 1'b0;
        step(1);

        // Hold for 10 cycles mid-play stretches play to 34 cycles.
        run_game(80, 13, 23, gr, pl, tu, eog, sn, eog_idx, sn_first, bad);
        check("g3_ready_cyc", gr, 8);
        check("g3_play_cyc", pl, 34);
        check("g3_tu_cyc", tu, 4);
        check("g3_eog_cnt", eog, 1);
        check("g3_eog_idx", eog_idx, 42);
        check("g3_snitch_cyc", sn, 8);
        check("g3_secs_frozen", secs_log[23], 5);
        check("g3_secs_presc_a", secs_log[25], 5);
        check("g3_secs_presc_b", secs_log[26], 4);
        check("g3_board", leaderboard, 1);

        // Abort in play with start also high.
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(10);
        check("abort_pre_play", playing, 1);
        abort = 1'b1;
        start = 1'b1;
        step(1);
        abort = 1'b0;
        start = 1'b0;
        check_quiet("abort");
        check("abort_screen", curr_screen, 0);
        cnt_eog = 0;
        cnt_gr = 0;
        for (int i = 0; i < 30; i++) begin
            step(1);
            cnt_eog += end_of_game;
            cnt_gr += get_ready;
        end
        check("abort_no_eog", cnt_eog, 0);
        check("abort_stay_idle", cnt_gr, 0);

        // Asynchronous reset in times-up.
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(32);
        check("rst_pre_tu", times_up, 1);
        check("rst_pre_eog", end_of_game, 1);
        #2 resetn = 1'b0;
        #1;
        check_quiet("rst_async");
        #1 resetn = 1'b1;
        step(1);
        check_quiet("rst_idle");
        check("rst_idle_scr0", curr_screen, 0);
        step(3);
        check("rst_idle_scr1", curr_screen, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
